multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//   Moore/Mealy control FSM that sequences a shared-memory multicycle MIPS datapath (PC, IR, regfile, ALU, one memory).
//   Decodes IR opcode/funct and drives per-state datapath strobes.
//   Stalls on a memory ready handshake, counts retired instructions, traps illegal ops and memory timeouts.
// PARAMETERS
//   CNT_WIDTH  32  width of retired-instruction counter
//   TIMEOUT    15  max cycles mem_req may wait for mem_ready before FAULT (>=1)
// PORTS
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous, active-low reset (0 = reset asserted)
//   opcode       in   6  IR[31:26]
//   funct        in   6  IR[5:0]
//   zero         in   1  ALU zero flag
//   mem_ready    in   1  memory completes the current access this cycle
//   mem_req      out  1  memory access request
//   iord         out  1  0 = address from PC, 1 = from ALUOut
//   mem_write    out  1  store strobe
//   ir_write     out  1  load IR
//   pc_en        out  1  PC load enable = pc_write | (branch & zero)
//   branch       out  1  BRANCH state indicator
//   reg_write    out  1  regfile write
//   reg_dst      out  1  1 = rd, 0 = rt
//   mem2reg      out  1  1 = write-back from MDR
//   alu_srca     out  1  0 = PC, 1 = A reg
//   alu_srcb     out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
//   pc_src       out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//   fault        out  1  sticky trap flag
//   illegal      out  1  fault cause: 1 = bad opcode/funct, 0 = mem timeout
//   retired      out  CNT_WIDTH  instructions completed, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//   Reset (reset=0, any time, including mid-instruction):
//     state=FETCH, retired=0, fault=0, illegal=0, wait counter=0.
//     All strobes deasserted while reset is held; FETCH resumes on the first clk edge after release.
//   Outputs are decoded from the state register. Exception: FETCH ir_write/pc_en are Mealy, qualified by mem_ready.
//   Unlisted outputs are 0. alu_control defaults to 010.
//   States and transitions:
//     FETCH: mem_req=1, iord=0, srca=0, srcb=01, add, pc_src=00.
//       On mem_ready: ir_write=1, pc_en=1 -> DECODE. Otherwise stay.
//     DECODE: srca=0, srcb=11, add (branch target into ALUOut). Dispatch on opcode:
//       000000 R  -> EXECUTE
//       100011 lw -> MEMADR
//       101011 sw -> MEMADR
//       000100 beq -> BRANCH
//       001000 addi -> ADDIEX
//       000010 j -> JUMP
//       other -> FAULT (illegal=1)
//     EXECUTE: srca=1, srcb=00, alu_control from funct:
//       100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt -> ALUWB
//       other funct -> FAULT (illegal=1)
//     ALUWB: reg_write=1, reg_dst=1, mem2reg=0 -> FETCH
//     MEMADR: srca=1, srcb=10, add -> MEMRD (lw) / MEMWR (sw)
//     MEMRD: mem_req=1, iord=1. On mem_ready -> MEMWB, else stay.
//     MEMWB: reg_write=1, reg_dst=0, mem2reg=1 -> FETCH
//     MEMWR: mem_req=1, iord=1, mem_write=1. On mem_ready -> FETCH, else stay.
//       mem_write is held for the whole wait.
//     BRANCH: srca=1, srcb=00, sub, pc_src=01, branch=1; pc_en=zero -> FETCH
//     ADDIEX: srca=1, srcb=10, add -> ADDIWB
//     ADDIWB: reg_write=1, reg_dst=0, mem2reg=0 -> FETCH
//     JUMP: pc_src=10, pc_en=1 -> FETCH
//     FAULT: all strobes 0, fault=1. Leaves only via reset.
//   Retirement: retired += 1 on every transition into FETCH from
//     ALUWB, MEMWB, MEMWR(ready), BRANCH, ADDIWB or JUMP. Never on entry to FAULT.
//   Timeout: wait counter clears on entry to FETCH/MEMRD/MEMWR and increments each mem_req cycle with mem_ready=0.
//     When the count reaches TIMEOUT with mem_ready still 0 -> FAULT (illegal=0).
//     mem_ready in the same cycle as the limit wins: the access completes, no fault.
//   Zero-wait latencies: R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3.
// TESTING
//   1. Release reset, mem_ready=1, opcode 000000 funct 100000:
//      FETCH,DECODE,EXECUTE,ALUWB in 4 cycles; reg_write=1 reg_dst=1 in ALUWB; retired=1.
//   2. lw with mem_ready low 3 cycles in MEMRD:
//      MEMRD held 4 cycles, mem_req=1 iord=1 throughout, then MEMWB mem2reg=1; total 8 cycles.
//   3. beq zero=1 -> pc_en=1 pc_src=01 in BRANCH; repeat with zero=0 -> pc_en=0; retired advances by 1 each.
//   4. opcode 111111 -> FAULT after DECODE, fault=1 illegal=1, all strobes 0, retired unchanged;
//      stays in FAULT 20 cycles; reset=0 clears.
//   5. TIMEOUT=15, mem_ready held 0 in FETCH -> fault=1 illegal=0 after 15 waits;
//      variant with ready on 15th cycle -> DECODE, no fault.
//   6. Assert reset=0 during MEMWR wait -> mem_write drops immediately; after release FETCH, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle MIPS control FSM.
// master: the controller (drives strobes), slave: the datapath / memory side.
interface multicycle_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 iord;
  logic                 mem_write;
  logic                 ir_write;
  logic                 pc_en;
  logic                 branch;
  logic                 reg_write;
  logic                 reg_dst;
  logic                 mem2reg;
  logic                 alu_srca;
  logic [1:0]           alu_srcb;
  logic [1:0]           pc_src;
  logic [2:0]           alu_control;
  logic                 fault;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, iord, mem_write, ir_write, pc_en, branch, reg_write,
           reg_dst, mem2reg, alu_srca, alu_srcb, pc_src, alu_control,
           fault, illegal, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, iord, mem_write, ir_write, pc_en, branch, reg_write,
           reg_dst, mem2reg, alu_srca, alu_srcb, pc_src, alu_control,
           fault, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over one shared
// memory, stalls on mem_ready, counts retired instructions and traps illegal
// opcodes/functs and memory timeouts into a sticky FAULT state.
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_FAULT
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                         ALU_OR = 3'b001, ALU_SLT = 3'b111;

  // Wait counter only needs to hold 0..TIMEOUT-1; reaching the last value
  // while still unready is the fault point.
  localparam int          WW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0] WLIMIT = WW'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] ret_q, ret_d;
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic                 fault_q, fault_d;
  logic                 illegal_q, illegal_d;

  logic                 fn_ok;
  logic [2:0]           fn_alu;
  logic                 waiting;

  // R-type funct decode
  always_comb begin
    fn_ok  = 1'b1;
    fn_alu = ALU_ADD;
    case (bus.funct)
      6'b100000: fn_alu = ALU_ADD;
      6'b100010: fn_alu = ALU_SUB;
      6'b100100: fn_alu = ALU_AND;
      6'b100101: fn_alu = ALU_OR;
      6'b101010: fn_alu = ALU_SLT;
      default:   fn_ok  = 1'b0;
    endcase
  end

  // Next-state, retirement, timeout and trap bookkeeping
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    wcnt_d    = wcnt_q;
    fault_d   = fault_q;
    illegal_d = illegal_q;
    waiting   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               waiting = 1'b1;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_R:         state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FAULT;
            fault_d   = 1'b1;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXECUTE: begin
        if (fn_ok) state_d = S_ALUWB;
        else begin
          state_d   = S_FAULT;
          fault_d   = 1'b1;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
        else               waiting = 1'b1;
      end
      S_MEMWR: begin
        if (bus.mem_ready) state_d = S_FETCH;
        else               waiting = 1'b1;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ALUWB, S_MEMWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FAULT;
    endcase

    // Ready on the limit cycle wins because waiting is only set when unready.
    if (waiting) begin
      if (wcnt_q == WLIMIT) begin
        state_d   = S_FAULT;
        fault_d   = 1'b1;
        illegal_d = 1'b0;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end

    if (state_d != state_q) wcnt_d = '0;

    // Every entry into FETCH from another state is a completed instruction.
    if (state_d == S_FETCH && state_q != S_FETCH) ret_d = ret_q + 1'b1;
  end

  // State and counters; reset may land mid-instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ret_q     <= '0;
      wcnt_q    <= '0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      wcnt_q    <= wcnt_d;
      fault_q   <= fault_d;
      illegal_q <= illegal_d;
    end
  end

  logic       mem_req_o, iord_o, mem_write_o, ir_write_o, pc_en_o, branch_o;
  logic       reg_write_o, reg_dst_o, mem2reg_o, alu_srca_o;
  logic [1:0] alu_srcb_o, pc_src_o;
  logic [2:0] alu_control_o;

  // Datapath strobes decoded from state; FETCH load strobes follow mem_ready
  always_comb begin
    mem_req_o     = 1'b0;
    iord_o        = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    pc_en_o       = 1'b0;
    branch_o      = 1'b0;
    reg_write_o   = 1'b0;
    reg_dst_o     = 1'b0;
    mem2reg_o     = 1'b0;
    alu_srca_o    = 1'b0;
    alu_srcb_o    = 2'b00;
    pc_src_o      = 2'b00;
    alu_control_o = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_o  = 1'b1;
        alu_srcb_o = 2'b01;
        ir_write_o = bus.mem_ready;
        pc_en_o    = bus.mem_ready;
      end
      S_DECODE:  alu_srcb_o = 2'b11;
      S_EXECUTE: begin
        alu_srca_o    = 1'b1;
        alu_control_o = fn_alu;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_srca_o = 1'b1;
        alu_srcb_o = 2'b10;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o = 1'b1;
        mem2reg_o   = 1'b1;
      end
      S_MEMWR: begin
        mem_req_o   = 1'b1;
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_srca_o    = 1'b1;
        alu_control_o = ALU_SUB;
        pc_src_o      = 2'b01;
        branch_o      = 1'b1;
        pc_en_o       = bus.zero;
      end
      S_ADDIWB: reg_write_o = 1'b1;
      S_JUMP: begin
        pc_src_o = 2'b10;
        pc_en_o  = 1'b1;
      end
      default: ;
    endcase
    // Reset forces FETCH, whose request must not leak out while held.
    if (!reset) begin
      mem_req_o  = 1'b0;
      ir_write_o = 1'b0;
      pc_en_o    = 1'b0;
      alu_srcb_o = 2'b00;
    end
  end

  assign bus.mem_req     = mem_req_o;
  assign bus.iord        = iord_o;
  assign bus.mem_write   = mem_write_o;
  assign bus.ir_write    = ir_write_o;
  assign bus.pc_en       = pc_en_o;
  assign bus.branch      = branch_o;
  assign bus.reg_write   = reg_write_o;
  assign bus.reg_dst     = reg_dst_o;
  assign bus.mem2reg     = mem2reg_o;
  assign bus.alu_srca    = alu_srca_o;
  assign bus.alu_srcb    = alu_srcb_o;
  assign bus.pc_src      = pc_src_o;
  assign bus.alu_control = alu_control_o;
  assign bus.fault       = fault_q;
  assign bus.illegal     = illegal_q;
  assign bus.retired     = ret_q;

endmodule
